// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
//   Converts a parallel operand pair (in_a, in_b) into an LSB-first bit-serial
//   stream of WIDTH beats for a downstream serial adder.
//
// Parameters
//   WIDTH      operand width in bits (1..64)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   in_valid   parallel operand pair offered
//   in_ready   pair accepted when in_valid & in_ready
//   in_a/in_b  parallel operands, bit 0 leaves first
//   en         downstream advance enable; low stalls the stream
//   out_vld    serial beat valid
//   out_a/b    serial operand bits (0 when out_vld is low)
//   out_last   final beat of an operand (0 when out_vld is low)
//   busy       operand in flight or pending
//
// Build option
//   SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN: adds a one-entry pending buffer
//   so consecutive operands stream with no bubble between them. Without it,
//   a new pair is only taken while idle.
`timescale 1ns/1ps

module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             en,
    output logic             out_vld,
    output logic             out_a,
    output logic             out_b,
    output logic             out_last,
    output logic             busy
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic beat;
    logic last_beat;
    logic accept;

`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
    logic [WIDTH-1:0] pa_q, pa_d;
    logic [WIDTH-1:0] pb_q, pb_d;
    logic             pfull_q, pfull_d;

    assign in_ready = !pfull_q;
    assign busy     = (state_q == SHIFT) | pfull_q;
`else
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == SHIFT);
`endif

    assign beat      = (state_q == SHIFT) & en;
    assign last_beat = beat & (cnt_q == LAST);
    assign accept    = in_valid & in_ready;

    // Outputs are gated by beat so they read 0 whenever no beat is presented.
    assign out_vld  = beat;
    assign out_a    = beat & sa_q[0];
    assign out_b    = beat & sb_q[0];
    assign out_last = last_beat;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
        pa_d    = pa_q;
        pb_d    = pb_q;
        pfull_d = pfull_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sa_d    = in_a;
                    sb_d    = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    sa_d  = sa_q >> 1;
                    sb_d  = sb_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end
                if (last_beat) begin
`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
                    // Chain the next operand in with no bubble: buffered pair
                    // first; a direct acceptance can only happen when the
                    // buffer is empty because in_ready is low while it is full.
                    if (pfull_q) begin
                        sa_d    = pa_q;
                        sb_d    = pb_q;
                        cnt_d   = '0;
                        pfull_d = 1'b0;
                    end else if (accept) begin
                        sa_d  = in_a;
                        sb_d  = in_b;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
                else if (accept) begin
                    pa_d    = in_a;
                    pb_d    = in_b;
                    pfull_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pa_q    <= '0;
            pb_q    <= '0;
            pfull_q <= 1'b0;
        end else begin
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pfull_q <= pfull_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_operand_serializer.sv
`timescale 1ns/1ps

module tb_serial_operand_serializer;

`ifdef SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif

    logic       clk;
    logic       rst;

    logic       vin4, en4, rdy4, vld4, oa4, ob4, last4, busy4;
    logic [3:0] a4, b4;

    logic       vin1, en1, rdy1, vld1, oa1, ob1, last1, busy1;
    logic [0:0] a1, b1;

    int n_chk;
    int n_pass;

    typedef struct {
        logic       vin;
        logic [3:0] a;
        logic [3:0] b;
        logic       en;
        logic       vld;
        logic       oa;
        logic       ob;
        logic       last;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    // Expected per-cycle traces, index 0 = first cycle of the sequence
    logic [0:10] e_vld, e_a, e_b, e_last, e_rdy;
    logic [0:6]  w_vld, w_a, w_b;
    logic [2:0]  pa1, pb1;
    logic [3:0]  fb;

    serial_operand_serializer #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vin4),
        .in_ready (rdy4),
        .in_a     (a4),
        .in_b     (b4),
        .en       (en4),
        .out_vld  (vld4),
        .out_a    (oa4),
        .out_b    (ob4),
        .out_last (last4),
        .busy     (busy4)
    );

    serial_operand_serializer #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vin1),
        .in_ready (rdy1),
        .in_a     (a1),
        .in_b     (b1),
        .en       (en1),
        .out_vld  (vld1),
        .out_a    (oa1),
        .out_b    (ob1),
        .out_last (last1),
        .busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void addv(input logic vin, input logic [3:0] a, input logic [3:0] b,
                                 input logic en, input logic vld, input logic oa,
                                 input logic ob, input logic last, input logic rdy,
                                 input logic busy);
        vec_t v;
        v.vin = vin; v.a = a; v.b = b; v.en = en;
        v.vld = vld; v.oa = oa; v.ob = ob; v.last = last; v.rdy = rdy; v.busy = busy;
        vq.push_back(v);
    endfunction

    initial begin
        int stg;
        n_chk = 0;
        n_pass = 0;

        // Single operand 1011 / 0110 with en held high
        addv(1, 4'hB, 4'h6, 1,  0, 0, 0, 0, 1,  0);
        addv(0, 4'h0, 4'h0, 1,  1, 1, 0, 0, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  1, 1, 1, 0, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  1, 0, 1, 0, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  1, 1, 0, 1, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  0, 0, 0, 0, 1,  0);
        // 0110 / 1001 with a two-cycle stall after beat 2; inputs wiggle meanwhile
        addv(1, 4'h6, 4'h9, 1,  0, 0, 0, 0, 1,  0);
        addv(0, 4'h0, 4'h0, 1,  1, 0, 1, 0, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  1, 1, 0, 0, PB, 1);
        addv(0, 4'hF, 4'hF, 0,  0, 0, 0, 0, PB, 1);
        addv(0, 4'hF, 4'hF, 0,  0, 0, 0, 0, PB, 1);
        addv(0, 4'hF, 4'hF, 1,  1, 1, 0, 0, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  1, 0, 1, 1, PB, 1);
        addv(0, 4'h0, 4'h0, 1,  0, 0, 0, 0, 1,  0);

        // Back-to-back pairs 5/3 then A/C
        e_vld  = PB ? 11'b01111111100 : 11'b01111011110;
        e_a    = PB ? 11'b01010010100 : 11'b01010001010;
        e_b    = PB ? 11'b01100001100 : 11'b01100000110;
        e_last = PB ? 11'b00001000100 : 11'b00001000010;
        e_rdy  = PB ? 11'b11000111111 : 11'b10000100001;

        // WIDTH=1 pairs (1,1),(0,1),(1,0)
        w_vld = PB ? 7'b0111000 : 7'b0101010;
        w_a   = PB ? 7'b0101000 : 7'b0100010;
        w_b   = PB ? 7'b0110000 : 7'b0101000;
        pa1   = 3'b101;
        pb1   = 3'b011;

        rst  = 1'b0;
        vin4 = 1'b0; a4 = '0; b4 = '0; en4 = 1'b1;
        vin1 = 1'b0; a1 = '0; b1 = '0; en1 = 1'b1;

        #3;
        check("reset vld",  vld4,  1'b0);
        check("reset a",    oa4,   1'b0);
        check("reset b",    ob4,   1'b0);
        check("reset last", last4, 1'b0);
        check("reset busy", busy4, 1'b0);
        check("reset vld w1", vld1, 1'b0);

        next_cycle();
        rst = 1'b1;
        #1;
        check("post-reset ready",    rdy4, 1'b1);
        check("post-reset ready w1", rdy1, 1'b1);
        next_cycle();

        // Table-driven vectors
        foreach (vq[i]) begin
            vin4 = vq[i].vin; a4 = vq[i].a; b4 = vq[i].b; en4 = vq[i].en;
            #1;
            check($sformatf("vec%0d vld", i),   vld4,  vq[i].vld);
            check($sformatf("vec%0d a", i),     oa4,   vq[i].oa);
            check($sformatf("vec%0d b", i),     ob4,   vq[i].ob);
            check($sformatf("vec%0d last", i),  last4, vq[i].last);
            check($sformatf("vec%0d ready", i), rdy4,  vq[i].rdy);
            check($sformatf("vec%0d busy", i),  busy4, vq[i].busy);
            next_cycle();
        end
        vin4 = 1'b0; en4 = 1'b1;

        // Back-to-back operand pairs
        stg = 0;
        for (int i = 0; i < 11; i++) begin
            vin4 = (stg < 2);
            a4   = (stg == 0) ? 4'h5 : 4'hA;
            b4   = (stg == 0) ? 4'h3 : 4'hC;
            #1;
            check($sformatf("b2b%0d vld", i),   vld4,  e_vld[i]);
            check($sformatf("b2b%0d a", i),     oa4,   e_a[i]);
            check($sformatf("b2b%0d b", i),     ob4,   e_b[i]);
            check($sformatf("b2b%0d last", i),  last4, e_last[i]);
            check($sformatf("b2b%0d ready", i), rdy4,  e_rdy[i]);
            if (vin4 && rdy4) stg++;
            next_cycle();
        end
        vin4 = 1'b0;
        check("b2b both accepted", (stg == 2), 1'b1);

        // Asynchronous reset after beat 2 of 9/6, with a second pair offered
        vin4 = 1'b1; a4 = 4'h9; b4 = 4'h6;
        #1;
        check("rst seq accept ready", rdy4, 1'b1);
        next_cycle();
        vin4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        #1;
        check("rst seq beat1 vld", vld4, 1'b1);
        check("rst seq beat1 a",   oa4,  1'b1);
        check("rst seq beat1 b",   ob4,  1'b0);
        next_cycle();
        vin4 = 1'b0;
        #1;
        check("rst seq beat2 vld",  vld4,  1'b1);
        check("rst seq beat2 a",    oa4,   1'b0);
        check("rst seq beat2 b",    ob4,   1'b1);
        check("rst seq beat2 last", last4, 1'b0);
        next_cycle();
        #1;
        rst = 1'b0;
        #1;
        check("rst async vld",  vld4,  1'b0);
        check("rst async a",    oa4,   1'b0);
        check("rst async b",    ob4,   1'b0);
        check("rst async last", last4, 1'b0);
        check("rst async busy", busy4, 1'b0);
        next_cycle();
        check("rst held vld",  vld4,  1'b0);
        check("rst held last", last4, 1'b0);
        rst = 1'b1;
        vin4 = 1'b1; a4 = 4'hF; b4 = 4'h1;
        #1;
        check("rst release ready", rdy4,  1'b1);
        check("rst release busy",  busy4, 1'b0);
        check("rst release vld",   vld4,  1'b0);
        next_cycle();
        vin4 = 1'b0; a4 = '0; b4 = '0;
        fb = 4'h1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("F/1 beat%0d vld", k),  vld4,  1'b1);
            check($sformatf("F/1 beat%0d a", k),    oa4,   1'b1);
            check($sformatf("F/1 beat%0d b", k),    ob4,   fb[k]);
            check($sformatf("F/1 beat%0d last", k), last4, (k == 3));
            next_cycle();
        end
        #1;
        check("F/1 after vld",  vld4,  1'b0);
        check("F/1 after busy", busy4, 1'b0);
        next_cycle();

        // WIDTH=1: every beat is a last beat
        stg = 0;
        for (int i = 0; i < 7; i++) begin
            vin1 = (stg < 3);
            a1   = (stg < 3) ? pa1[stg] : 1'b0;
            b1   = (stg < 3) ? pb1[stg] : 1'b0;
            #1;
            check($sformatf("w1 c%0d vld", i),  vld1,  w_vld[i]);
            check($sformatf("w1 c%0d a", i),    oa1,   w_a[i]);
            check($sformatf("w1 c%0d b", i),    ob1,   w_b[i]);
            check($sformatf("w1 c%0d last", i), last1, w_vld[i]);
            if (vin1 && rdy1) stg++;
            next_cycle();
        end
        vin1 = 1'b0;
        check("w1 all accepted", (stg == 3), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_operand_serializer.md
SERIAL_OPERAND_SERIALIZER -- requirements
Module: serial_operand_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 1..64.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  parallel operand pair offered.
REQ-005 SHALL have port in_ready  output  1  operand pair accepted on a cycle where in_valid & in_ready.
REQ-006 SHALL have ports in_a, in_b  input  WIDTH  parallel operands, LSB = first serial bit.
REQ-007 SHALL have port en  input  1  downstream advance enable; low stalls the serial stream.
REQ-008 SHALL have ports out_vld, out_a, out_b, out_last  output  1 each  serial beat to the downstream serial adder.
REQ-009 SHALL have port busy  output  1  an operand is in flight or pending.

Function
REQ-010 SHALL implement states IDLE and SHIFT, with WIDTH-bit shift registers sa/sb and a bit counter cnt of width max(1,$clog2(WIDTH)).
REQ-011 SHALL load sa/sb from in_a/in_b, clear cnt and enter SHIFT on an accepted transfer while IDLE.
REQ-012 SHALL present the first beat (out_vld=1) on the cycle after acceptance; latency = 1 cycle.
REQ-013 SHALL drive out_vld = (state==SHIFT) & en, out_a = sa[0], out_b = sb[0], out_last = (cnt==WIDTH-1), all combinational from registers and en.
REQ-014 SHALL force out_a, out_b and out_last to 0 whenever out_vld is 0.
REQ-015 SHALL, on each beat (out_vld=1), shift sa/sb right by one and increment cnt; with en=0 all state is held and no beat is consumed.
REQ-016 SHALL, on the out_last beat, return to IDLE unless a next operand is available per REQ-021/REQ-022.
REQ-017 SHALL assert out_last on every beat when WIDTH==1.
REQ-018 SHALL never ignore a beat: exactly WIDTH out_vld beats per accepted pair, exactly one of them with out_last.
REQ-019 SHALL hold in_a/in_b sampled at acceptance; later changes on the inputs have no effect on the stream.
REQ-020 SHALL drive busy = (state==SHIFT) | pending-buffer full.

Reset
REQ-023 SHALL, on rst low, asynchronously clear state to IDLE, sa, sb and cnt to 0, and the pending buffer to empty; out_vld, out_a, out_b, out_last and busy read 0.
REQ-024 SHALL, on rst low mid-operand, discard the in-flight and pending operands with no out_last emitted; the downstream adder shares this reset.
REQ-025 SHALL present in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-021 SHALL, with macro SERIAL_OPERAND_SERIALIZER_PENDING_BUF_EN defined:
- include a one-entry pending buffer; in_ready = !pending_full.
- an acceptance during SHIFT is written to the buffer.
- on the out_last beat, load a full buffer into sa/sb (buffer empties) or, if in_valid & in_ready that cycle, load in_a/in_b directly; SHIFT continues with zero bubble cycles.
- simultaneous out_last and acceptance with a full buffer cannot occur (in_ready=0).
REQ-022 SHALL, with the macro undefined, omit the buffer: in_ready = (state==IDLE); at least one idle cycle separates consecutive operands.

Verification
REQ-026 SHALL pass: WIDTH=4, in_a=4'b1011, in_b=4'b0110, en=1 -> out_a 1,1,0,1; out_b 0,1,1,0; out_last only on beat 4; out_vld low before and after.
REQ-027 SHALL pass: macro defined, WIDTH=4, two pairs offered back-to-back -> 8 consecutive out_vld cycles, out_last on cycles 4 and 8; in_ready low after the second acceptance until the first out_last.
REQ-028 SHALL pass: macro undefined, same stimulus -> second pair accepted the cycle after first out_last; exactly one out_vld=0 bubble between the streams.
REQ-029 SHALL pass: WIDTH=4, en=0 for two cycles after beat 2 -> out_vld=0 and outputs 0 for those cycles; beats 3 and 4 then resume unchanged, last on beat 4.
REQ-030 SHALL pass: rst low asynchronously after beat 2 of 4 -> outputs 0 immediately, no out_last; after release in_ready=1 and a new pair 4'hF/4'h1 streams correctly.
REQ-031 SHALL pass: WIDTH=1, three pairs (1,1),(0,1),(1,0) with macro defined -> three consecutive beats, each with out_last=1.
